// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end over one bit-serial full adder (LSB first).
// Define SERIAL_SUB_EN to add per-requester subtract mode (sub0/sub1 ports).
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic [1:0]       ack,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_SUB_EN
  ,
  input  logic             sub0,
  input  logic             sub1
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, owner_q, owner_d, last_q, last_d;
  logic [1:0]       ack_q, ack_d;
  logic             done_q, done_d, done_id_q, done_id_d, cout_q, cout_d;
  logic             grant_s, win_s, b_bit_s, fa_s, fa_co;
`ifdef SERIAL_SUB_EN
  logic             sub_q, sub_d;
`endif

  // Round-robin pick: on contention the requester that did not win last time gets it.
  always_comb begin
    grant_s = (state_q == IDLE) && (req != 2'b00);
    win_s   = 1'b0;
    case (req)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = ~last_q;
      default: win_s = 1'b0;
    endcase
  end

`ifdef SERIAL_SUB_EN
  assign b_bit_s = b_q[0] ^ sub_q;
`else
  assign b_bit_s = b_q[0];
`endif

  fulladder u_fa (
    .a  (a_q[0]),
    .b  (b_bit_s),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    ack_d     = 2'b00;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef SERIAL_SUB_EN
    sub_d     = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          a_d     = win_s ? a1 : a0;
          b_d     = win_s ? b1 : b0;
          carry_d = win_s ? cin1 : cin0;
`ifdef SERIAL_SUB_EN
          sub_d   = win_s ? sub1 : sub0;
          if (win_s ? sub1 : sub0) begin
            carry_d = 1'b1;
          end else begin
            carry_d = win_s ? cin1 : cin0;
          end
`endif
          ack_d   = win_s ? 2'b10 : 2'b01;
          last_d  = win_s;
          owner_d = win_s;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          ack_d = 2'b00;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          done_d    = 1'b1;
          done_id_d = owner_q;
          sum_d     = {fa_s, res_q[WIDTH-1:1]};
          cout_d    = fa_co;
        end else begin
          done_d = 1'b0;
        end
      end
      DONE:    done_d = 1'b0;
      default: done_d = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      ack_q     <= 2'b00;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
`ifdef SERIAL_SUB_EN
      sub_q     <= sub_d;
`endif
    end
  end

  assign ack     = ack_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed, table-driven bench for serial_add_arbiter (WIDTH=8); covers SERIAL_SUB_EN when defined.
module tb_serial_add_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic         cin0, cin1, sub0, sub1;
  logic [1:0]   ack;
  logic         busy, done, done_id, cout;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a0(a0), .b0(b0), .cin0(cin0),
    .a1(a1), .b1(b1), .cin1(cin1),
    .ack(ack), .busy(busy), .done(done), .done_id(done_id),
    .sum(sum), .cout(cout)
`ifdef SERIAL_SUB_EN
    , .sub0(sub0), .sub1(sub1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One request from requester id; checks ack, latency, result and post-done state.
  task automatic do_op(input string nm, input vec_t v);
    int   lat;
    logic got;
    logic extra_ack;
    @(negedge clk);
    req = v.id ? 2'b10 : 2'b01;
    if (v.id) begin
      a1 = v.a; b1 = v.b; cin1 = v.cin; sub1 = v.sub;
      a0 = ~v.a; b0 = ~v.b; cin0 = ~v.cin; sub0 = 1'b0;
    end else begin
      a0 = v.a; b0 = v.b; cin0 = v.cin; sub0 = v.sub;
      a1 = ~v.a; b1 = ~v.b; cin1 = ~v.cin; sub1 = 1'b0;
    end
    @(negedge clk);
    req = 2'b00;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    chk({nm, "_ack"}, {30'd0, ack}, v.id ? 32'd2 : 32'd1);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0; got = 1'b0; extra_ack = 1'b0;
    for (int k = 1; k <= W + 4 && !got; k++) begin
      @(negedge clk);
      if (ack != 2'b00) extra_ack = 1'b1;
      if (done) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk({nm, "_latency"}, lat, W);
    chk({nm, "_ackpulse"}, {31'd0, extra_ack}, 32'd0);
    chk({nm, "_sum"}, {24'd0, sum}, {24'd0, v.es});
    chk({nm, "_cout"}, {31'd0, cout}, {31'd0, v.ec});
    chk({nm, "_doneid"}, {31'd0, done_id}, {31'd0, v.id});
    @(negedge clk);
    chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done_after"}, {31'd0, done}, 32'd0);
    chk({nm, "_sum_hold"}, {24'd0, sum}, {24'd0, v.es});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic got;
    int   ndone;
    logic [1:0] exp_ack;
    logic [W-1:0] exp_sum;

    vecs[0] = '{1'b0, 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h7F, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{1'b0, 8'h3C, 8'h4E, 1'b1, 1'b0, 8'h8B, 1'b0};

    req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    cin0 = 1'b0; cin1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_doneid", {31'd0, done_id}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);

    // Simultaneous requests straight after reset, then fairness over 4 ops.
    a0 = 8'h01; b0 = 8'h02; cin0 = 1'b0;
    a1 = 8'h10; b1 = 8'h20; cin1 = 1'b0;
    req = 2'b11;
    for (int op = 0; op < 4; op++) begin
      exp_ack = (op % 2 == 0) ? 2'b01 : 2'b10;
      exp_sum = (op % 2 == 0) ? 8'h03 : 8'h30;
      lat = 0; got = 1'b0;
      for (int k = 1; k <= W + 6 && !got; k++) begin
        @(negedge clk);
        if (ack != 2'b00) begin
          got = 1'b1;
          lat = k;
        end
      end
      if (op == 0) chk("fair_first_ack_lat", lat, 1);
      else         chk($sformatf("fair%0d_gap", op), lat, 2);
      chk($sformatf("fair%0d_ack", op), {30'd0, ack}, {30'd0, exp_ack});
      lat = 0; got = 1'b0;
      for (int k = 1; k <= W + 4 && !got; k++) begin
        @(negedge clk);
        if (done) begin
          got = 1'b1;
          lat = k;
        end
      end
      chk($sformatf("fair%0d_lat", op), lat, W);
      chk($sformatf("fair%0d_doneid", op), {31'd0, done_id}, {31'd0, exp_ack[1]});
      chk($sformatf("fair%0d_sum", op), {24'd0, sum}, {24'd0, exp_sum});
    end
    req = 2'b00;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while RUN is at bit 4: everything clears, no done follows.
    @(negedge clk);
    req = 2'b01; a0 = 8'hC3; b0 = 8'h11; cin0 = 1'b1;
    @(negedge clk);
    req = 2'b00;
    chk("midrst_ack", {30'd0, ack}, 32'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ack0", {30'd0, ack}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sum", {24'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    chk("midrst_doneid", {31'd0, done_id}, 32'd0);
    ndone = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("midrst_quiet", ndone, 0);
    do_op("after_rst", '{1'b0, 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0});

`ifdef SERIAL_SUB_EN
    do_op("sub_a", '{1'b0, 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    do_op("sub_b", '{1'b0, 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0});
    do_op("sub_c", '{1'b1, 8'h40, 8'h40, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
